// File: rtl/cpu_read_arbiter.sv
// Z80 data-in read sequencer: registered one-hot grant, per-source waits.
// Optional saturating clash counter: CPU_READ_CLASH_COUNT_EN.
module cpu_read_arbiter #(
  parameter int NSRC    = 16,
  parameter int WS_BITS = 4
) (
  input  logic                    pll0_250MHz,
  input  logic                    reset,
  input  logic                    z80Read,
  input  logic [NSRC-1:0]         req,
  input  logic [NSRC*WS_BITS-1:0] waitCfg,
  output logic [NSRC-1:0]         grant,
  output logic                    defaultSel,
  output logic                    z80Wait,
  output logic                    dataValid,
  output logic                    clash
`ifdef CPU_READ_CLASH_COUNT_EN
  ,
  output logic [7:0]              clashCount
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    WAITST,
    VALID
  } state_t;

  state_t state_q, state_d;

  logic [NSRC-1:0]    grant_q, grant_d;
  logic               dflt_q, dflt_d;
  logic               wait_q, wait_d;
  logic               valid_q, valid_d;
  logic               clash_q, clash_d;
  logic [WS_BITS-1:0] cnt_q, cnt_d;
`ifdef CPU_READ_CLASH_COUNT_EN
  logic [7:0]         ccnt_q, ccnt_d;
`endif

  logic [NSRC-1:0]    win_oh;
  logic [WS_BITS-1:0] win_ws;
  logic               multi;

  // Isolating the lowest set bit gives the priority winner directly.
  always_comb begin
    win_oh = req & (~req + NSRC'(1));
    multi  = |(req & (req - NSRC'(1)));
    win_ws = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_ws = waitCfg[i*WS_BITS +: WS_BITS];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    dflt_d  = dflt_q;
    wait_d  = 1'b0;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    clash_d = clash_q;
`ifdef CPU_READ_CLASH_COUNT_EN
    ccnt_d  = ccnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        grant_d = '0;
        dflt_d  = 1'b0;
        if (z80Read) begin
          state_d = ARB;
        end
      end
      ARB: begin
        if (!z80Read) begin
          state_d = IDLE;
          grant_d = '0;
          dflt_d  = 1'b0;
        end else begin
          grant_d = win_oh;
          dflt_d  = (req == '0);
          cnt_d   = win_ws;
          if (multi) begin
            clash_d = 1'b1;
`ifdef CPU_READ_CLASH_COUNT_EN
            if (ccnt_q != 8'hFF) begin
              ccnt_d = ccnt_q + 8'd1;
            end
`endif
          end
          if (win_ws != '0) begin
            state_d = WAITST;
            wait_d  = 1'b1;
          end else begin
            state_d = VALID;
          end
        end
      end
      WAITST: begin
        if (!z80Read) begin
          state_d = IDLE;
          grant_d = '0;
          dflt_d  = 1'b0;
        end else if (cnt_q == WS_BITS'(1)) begin
          state_d = VALID;
        end else begin
          cnt_d  = cnt_q - WS_BITS'(1);
          wait_d = 1'b1;
        end
      end
      VALID: begin
        // First VALID cycle lets the registered mux settle.
        if (!z80Read) begin
          state_d = IDLE;
          grant_d = '0;
          dflt_d  = 1'b0;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        dflt_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pll0_250MHz) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      dflt_q  <= 1'b0;
      wait_q  <= 1'b0;
      valid_q <= 1'b0;
      clash_q <= 1'b0;
      cnt_q   <= '0;
`ifdef CPU_READ_CLASH_COUNT_EN
      ccnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      dflt_q  <= dflt_d;
      wait_q  <= wait_d;
      valid_q <= valid_d;
      clash_q <= clash_d;
      cnt_q   <= cnt_d;
`ifdef CPU_READ_CLASH_COUNT_EN
      ccnt_q  <= ccnt_d;
`endif
    end
  end

  assign grant      = grant_q;
  assign defaultSel = dflt_q;
  assign z80Wait    = wait_q;
  assign dataValid  = valid_q;
  assign clash      = clash_q;
`ifdef CPU_READ_CLASH_COUNT_EN
  assign clashCount = ccnt_q;
`endif

endmodule

// File: tb/tb_cpu_read_arbiter.sv
// Directed bench for cpu_read_arbiter.
// Clash-counter checks build only with CPU_READ_CLASH_COUNT_EN.
module tb_cpu_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        z80Read;
  logic [15:0] req;
  logic [63:0] waitCfg;
  logic [15:0] grant;
  logic        defaultSel;
  logic        z80Wait;
  logic        dataValid;
  logic        clash;
`ifdef CPU_READ_CLASH_COUNT_EN
  logic [7:0]  clashCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_read_arbiter #(
    .NSRC(16),
    .WS_BITS(4)
  ) dut (
    .pll0_250MHz(clk),
    .reset(reset),
    .z80Read(z80Read),
    .req(req),
    .waitCfg(waitCfg),
    .grant(grant),
    .defaultSel(defaultSel),
    .z80Wait(z80Wait),
    .dataValid(dataValid),
    .clash(clash)
`ifdef CPU_READ_CLASH_COUNT_EN
    ,
    .clashCount(clashCount)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // {grant, defaultSel, z80Wait, dataValid} as one comparison
  task automatic out(
    input string       tag,
    input logic [15:0] g,
    input logic        d,
    input logic        w,
    input logic        v
  );
    chk(tag,
        32'({grant, defaultSel, z80Wait, dataValid}),
        32'({g, d, w, v}));
  endtask

  initial begin
    reset   = 1'b1;
    z80Read = 1'b0;
    req     = 16'h0;
    waitCfg = 64'h0;
    tick();
    tick();
    reset = 1'b0;
    out("rst_out", 16'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_clash", 32'(clash), 32'h0);

    // single source, no waits
    req     = 16'h0001;
    z80Read = 1'b1;
    tick();
    out("s_arb", 16'h0, 1'b0, 1'b0, 1'b0);
    tick();
    out("s_grant", 16'h0001, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 6; i++) begin
      tick();
      out($sformatf("s_valid%0d", i),
          16'h0001, 1'b0, 1'b0, 1'b1);
    end
    z80Read = 1'b0;
    tick();
    out("s_idle", 16'h0, 1'b0, 1'b0, 1'b0);

    // five wait states on source 14
    waitCfg = 64'h0500_0000_0000_0000;
    req     = 16'h4000;
    z80Read = 1'b1;
    tick();
    out("w_arb", 16'h0, 1'b0, 1'b0, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      tick();
      out($sformatf("w_e%0d", j), 16'h4000, 1'b0,
          (j <= 5), (j >= 7));
    end
    z80Read = 1'b0;
    tick();
    out("w_idle", 16'h0, 1'b0, 1'b0, 1'b0);
    chk("w_noclash", 32'(clash), 32'h0);

    // clash: bits 1 and 4
    req     = 16'h0012;
    z80Read = 1'b1;
    tick();
    tick();
    out("c_grant", 16'h0002, 1'b0, 1'b0, 1'b0);
    chk("c_clash", 32'(clash), 32'h1);
    tick();
    out("c_valid", 16'h0002, 1'b0, 1'b0, 1'b1);
    z80Read = 1'b0;
    tick();
    out("c_idle", 16'h0, 1'b0, 1'b0, 1'b0);
    chk("c_sticky", 32'(clash), 32'h1);
`ifdef CPU_READ_CLASH_COUNT_EN
    chk("c_cnt1", 32'(clashCount), 32'd1);
    for (int r = 0; r < 299; r++) begin
      z80Read = 1'b1;
      tick();
      tick();
      tick();
      z80Read = 1'b0;
      tick();
    end
    chk("c_cnt_sat", 32'(clashCount), 32'd255);
`endif

    // default path, then req change ignored
    req     = 16'h0;
    z80Read = 1'b1;
    tick();
    tick();
    out("d_sel", 16'h0, 1'b1, 1'b0, 1'b0);
    tick();
    out("d_valid", 16'h0, 1'b1, 1'b0, 1'b1);
    req = 16'h0008;
    tick();
    out("d_hold", 16'h0, 1'b1, 1'b0, 1'b1);
    z80Read = 1'b0;
    tick();
    out("d_idle", 16'h0, 1'b0, 1'b0, 1'b0);

    // abort during wait states
    waitCfg = {16{4'hF}};
    req     = 16'h0004;
    z80Read = 1'b1;
    tick();
    tick();
    out("a_wait1", 16'h0004, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    out("a_wait4", 16'h0004, 1'b0, 1'b1, 1'b0);
    z80Read = 1'b0;
    tick();
    out("a_abort", 16'h0, 1'b0, 1'b0, 1'b0);

    // reset while VALID
    waitCfg = 64'h0;
    req     = 16'h0001;
    z80Read = 1'b1;
    tick();
    tick();
    tick();
    out("r_valid", 16'h0001, 1'b0, 1'b0, 1'b1);
    reset   = 1'b1;
    z80Read = 1'b0;
    tick();
    out("r_out", 16'h0, 1'b0, 1'b0, 1'b0);
    chk("r_clash", 32'(clash), 32'h0);
`ifdef CPU_READ_CLASH_COUNT_EN
    chk("r_cnt", 32'(clashCount), 32'd0);
`endif
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
